sift_out_serial_adder_ctrl: RTL
===============================

# sift_out_serial_adder_ctrl

Bit-serial sequencer that drives the triplicated sift-out full adder. It accepts W-bit operand pairs over a valid/ready handshake and feeds them to the adder one bit per clock, LSB first, with registered carry feedback. It collects the sum and carry back into a W-bit result, so the single fault-tolerant full-adder cell implements a W-bit adder. It also owns the adder's fault-flag clear line (K).

## Interface
- `W`, 8, operand/result width; legal range W ≥ 2
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `s_valid`  in  1  operand request valid
- `s_ready`  out  1  controller can accept operands
- `s_a`, `s_b`  in  W  operands
- `s_cin`  in  1  carry-in for bit 0
- `m_valid`  out  1  result valid
- `m_ready`  in  1  consumer accepts result
- `m_sum`  out  W  result sum
- `m_cout`  out  1  carry out of bit W-1
- `busy`  out  1  high in RUN or DONE
- `fault_clr`  in  1  request to clear the adder's fault flip-flops
- `fa_in1`, `fa_in2`, `fa_cin`  out  1  bit drive to the sift-out adder
- `fa_sum`, `fa_cout`  in  1  bit results from the sift-out adder
- `fa_k`  out  1  K line to the adder's fault JK flip-flops
- `chk_err`  out  1  self-check mismatch; see Configuration
- One clock (`clk`). Reset `rst_n` is asynchronous and active-low.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values:
  - all outputs 0, except `s_ready`, which is 1 after reset when `fault_clr` is 0
  - shift registers, carry register and bit counter all 0
- IDLE:
  - `s_ready = !fault_clr`.
  - `fa_in1`, `fa_in2` and `fa_cin` are driven 0.
  - If `fault_clr` is high, `fa_k` is 1 for exactly that cycle. No operand is accepted in that cycle; clear has priority.
  - On `s_valid && s_ready`: load the A/B shift registers, set `carry_q = s_cin`, set counter = 0, go to RUN.
- RUN:
  - Drive `fa_in1 = a_sr[0]`, `fa_in2 = b_sr[0]`, `fa_cin = carry_q`.
  - Each edge: shift A/B right; shift `fa_sum` into the result register MSB (shift right); `carry_q <= fa_cout`; counter increments.
  - On the edge with counter == W-1: go to DONE.
  - `fault_clr` is ignored in RUN and DONE. `fa_k` is 0.
- DONE:
  - `m_valid = 1`.
  - `m_sum` and `m_cout` hold the registered values and are stable until the handshake completes.
  - On `m_ready`: go to IDLE.
  - `fa_*` outputs are driven 0.
- Arithmetic: `{m_cout, m_sum} = s_a + s_b + s_cin`, modulo 2^(W+1). All registers are unsigned.
- Reset mid-operation: the operation in flight is discarded, no `m_valid` is produced, and the FSM returns to IDLE immediately (asynchronous).
- `m_valid` never asserts in the same cycle as `s_ready`.

## Timing
- The `fa_*` inputs come combinationally from the adder. The adder is driven from registered `fa_*` outputs, so no combinational loop exists.
- Operands accepted at edge E are processed in cycles E+1 … E+W.
- `m_valid` rises after edge E+W, i.e. W cycles of latency.
- Minimum issue interval is W+2 cycles: one IDLE, W RUN, one DONE with `m_ready` already high.
- `fa_k` is a single-cycle pulse. It is never asserted in a cycle where `fa_in*` is nonzero.
- The counter is `$clog2(W)` bits wide. It never wraps inside an operation.

## Configuration
- `SERIAL_ADD_CHECK_EN` defined:
  - On acceptance, a golden value `s_a + s_b + s_cin` (W+1 bits) is registered.
  - In DONE, `chk_err` is 1 if the golden value ≠ `{m_cout, m_sum}`.
  - An internal 8-bit saturating `err_cnt` increments once per mismatched result, on the `m_ready` handshake.
- `SERIAL_ADD_CHECK_EN` undefined: `chk_err` is tied 0 and no golden or counter logic exists.

## Structure
- Shared package `sift_out_pkg` holds:
  - the FSM state enum typedef (IDLE/RUN/DONE)
  - the default width constant `SIFT_W_DEF = 8`
- One sub-module, `serial_add_checker`: golden register, comparator and `err_cnt`. It is instantiated only under `SERIAL_ADD_CHECK_EN`.
- The sift-out full adder is not instantiated inside this block. Both are wired together at the next level up.

## Test plan
All scenarios use W = 8.
- `s_a=0x5A`, `s_b=0x33`, `s_cin=0` → `m_sum=0x8D`, `m_cout=0`, with `m_valid` exactly 8 cycles after acceptance.
- `0xFF + 0x01`, cin 0 → `m_sum=0x00`, `m_cout=1`. Then `0xFF + 0xFF`, cin 1 → `m_sum=0xFF`, `m_cout=1`.
- Back-pressure: hold `m_ready=0` for 5 cycles in DONE → `m_sum`/`m_cout` stable, `s_ready=0`, `busy=1`. After `m_ready=1`, the next operand is accepted the cycle after returning to IDLE.
- `fault_clr` and `s_valid` high in the same IDLE cycle → `fa_k=1` for one cycle with `fa_in*=0` and `s_ready=0`. The operand is accepted the following cycle.
- `rst_n` low during bit 3 of RUN → all outputs 0 immediately, IDLE. After release, `s_ready=1` and no `m_valid` appears.
- With `SERIAL_ADD_CHECK_EN`, force the bench adder model's `fa_sum` stuck-at-0 and add `0x0F + 0x00` → `chk_err=1` in DONE, and `err_cnt` goes 0 → 1 on the handshake.

Source files
------------

// File: rtl/sift_out_serial_adder_ctrl_pkg.sv
// Shared types for the sift-out serial adder controller: FSM state encoding and default width.
package sift_out_pkg;

    localparam int SIFT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sift_out_serial_adder_ctrl_if.sv
// Operand request / result handshake bundle between a host (master) and the serial adder controller (slave).
interface sift_out_serial_adder_ctrl_if
    import sift_out_pkg::*;
#(
    parameter int W = SIFT_W_DEF
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_a;
    logic [W-1:0] s_b;
    logic         s_cin;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_sum;
    logic         m_cout;

    modport master (
        output s_valid, s_a, s_b, s_cin, m_ready,
        input  s_ready, m_valid, m_sum, m_cout
    );

    modport slave (
        input  s_valid, s_a, s_b, s_cin, m_ready,
        output s_ready, m_valid, m_sum, m_cout
    );

endinterface

// File: rtl/sift_out_serial_adder_ctrl_chk.sv
// Golden-sum checker (built only with SERIAL_ADD_CHECK_EN): flags a wrong serial result in DONE
// and counts mismatched results in a saturating 8-bit err_cnt, bumped on the result handshake.
module serial_add_checker #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         done,
    input  logic         ack,
    input  logic [W-1:0] sum,
    input  logic         cout,
    output logic         chk_err
);
    logic [W:0] golden;
    logic [7:0] err_cnt;

    assign chk_err = done && (golden != {cout, sum});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            golden  <= '0;
            err_cnt <= '0;
        end else begin
            if (load) begin
                golden <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            end
            if (ack && chk_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sift_out_serial_adder_ctrl.sv
// Bit-serial W-bit adder sequencer around one sift-out full-adder cell; W cycles accept-to-result,
// result held in DONE until m_ready, no new operand while busy. SERIAL_ADD_CHECK_EN adds a golden self-check.
module sift_out_serial_adder_ctrl
    import sift_out_pkg::*;
#(
    parameter int W = SIFT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sift_out_serial_adder_ctrl_if.slave  bus,
    output logic                         busy,
    input  logic                         fault_clr,
    output logic                         fa_in1,
    output logic                         fa_in2,
    output logic                         fa_cin,
    input  logic                         fa_sum,
    input  logic                         fa_cout,
    output logic                         fa_k,
    output logic                         chk_err
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_sr, b_sr, res_sr;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic          rdy, vld, accept;

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        vld     = 1'b0;
        accept  = 1'b0;
        fa_in1  = 1'b0;
        fa_in2  = 1'b0;
        fa_cin  = 1'b0;
        fa_k    = 1'b0;
        case (state_q)
            IDLE: begin
                // A clear request wins over an operand offered in the same cycle.
                rdy    = !fault_clr;
                fa_k   = fault_clr;
                accept = bus.s_valid && !fault_clr;
                if (accept) state_d = RUN;
            end
            RUN: begin
                fa_in1 = a_sr[0];
                fa_in2 = b_sr[0];
                fa_cin = carry_q;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                vld = 1'b1;
                if (bus.m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sr    <= bus.s_a;
                b_sr    <= bus.s_b;
                carry_q <= bus.s_cin;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                res_sr  <= {fa_sum, res_sr[W-1:1]};
                carry_q <= fa_cout;
                cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    assign bus.s_ready = rdy;
    assign bus.m_valid = vld;
    assign bus.m_sum   = res_sr;
    // After the last RUN edge the carry register holds the carry out of bit W-1.
    assign bus.m_cout  = carry_q;
    assign busy        = (state_q != IDLE);

`ifdef SERIAL_ADD_CHECK_EN
    serial_add_checker #(.W(W)) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .a       (bus.s_a),
        .b       (bus.s_b),
        .cin     (bus.s_cin),
        .done    (vld),
        .ack     (vld && bus.m_ready),
        .sum     (res_sr),
        .cout    (carry_q),
        .chk_err (chk_err)
    );
`else
    assign chk_err = 1'b0;
`endif

endmodule
